// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses "m n e0 e1 ..." from a UART byte stream, requests
// storage from the matrix manager, writes elements into BRAM and commits.
// Every byte accepted while parsing is echoed through a small FIFO, and
// 'C' / 'E' status bytes are queued behind the echo.
// Optional feature: define MATRIX_INPUT_SIGNED_EN to accept a leading '-' on
// element tokens (two's complement writes). Without it, '-' is a syntax error.
//
// state      | meaning
// IDLE       | clear accumulator, counters and error; enter PARSE_M
// PARSE_M    | accumulating row count token
// PARSE_N    | accumulating column count token
// CHECK_DIM  | validate dims, raise alloc_req
// WAIT_ALLOC | wait for ack/fail, bounded by the alloc timer
// PARSE_DATA | accumulate element tokens, write each to BRAM
// COMMIT     | pulse commit_req with slot/dims/base
// DONE       | queue 'C', back to IDLE
// ERROR      | queue 'E' once, hold until mode_active drops
module matrix_input_parser #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int MAX_DIGITS    = 3,
  parameter int ECHO_DEPTH    = 8,
  parameter int ALLOC_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active_i,
  input  logic [3:0]               cfg_max_dim_i,
  input  logic [ELEMENT_WIDTH-1:0] cfg_max_value_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_done_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_start_o,
  input  logic                     tx_busy_i,
  output logic                     alloc_req_o,
  output logic [3:0]               alloc_m_o,
  output logic [3:0]               alloc_n_o,
  input  logic                     alloc_ack_i,
  input  logic                     alloc_fail_i,
  input  logic [3:0]               alloc_slot_i,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr_i,
  output logic                     commit_req_o,
  output logic [3:0]               commit_slot_o,
  output logic [3:0]               commit_m_o,
  output logic [3:0]               commit_n_o,
  output logic [ADDR_WIDTH-1:0]    commit_addr_o,
  output logic                     mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr_o,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data_o,
  output logic [3:0]               error_code_o,
  output logic [3:0]               state_out_o
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_PARSE_M    = 4'd1;
  localparam logic [3:0] S_PARSE_N    = 4'd2;
  localparam logic [3:0] S_CHECK_DIM  = 4'd3;
  localparam logic [3:0] S_WAIT_ALLOC = 4'd4;
  localparam logic [3:0] S_PARSE_DATA = 4'd5;
  localparam logic [3:0] S_COMMIT     = 4'd6;
  localparam logic [3:0] S_DONE       = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;

  localparam logic [3:0] E_NONE  = 4'd0;
  localparam logic [3:0] E_DIM   = 4'd1;
  localparam logic [3:0] E_VALUE = 4'd2;
  localparam logic [3:0] E_SPACE = 4'd3;
  localparam logic [3:0] E_SYNTAX = 4'd4;

  // 4 bits per decimal digit always covers MAX_DIGITS digits plus one overflow digit.
  localparam int ACC_W = 4 * (MAX_DIGITS + 1);
  localparam int CMP_W = (ACC_W > ELEMENT_WIDTH) ? ACC_W : ELEMENT_WIDTH;
  localparam int DC_W  = $clog2(MAX_DIGITS + 2);
  localparam int TMR_W = $clog2(ALLOC_TIMEOUT + 1);
  localparam int PW    = $clog2(ECHO_DEPTH);
  localparam int CNT_W = PW + 1;

  logic [3:0]               state_q, state_d;
  logic [3:0]               err_q, err_d;
  logic [ACC_W-1:0]         acc_q, acc_nx;
  logic [DC_W-1:0]          dcnt_q, dcnt_nx;
  logic                     sign_q;
  logic [ACC_W-1:0]         m_q, n_q;
  logic [7:0]               total_q, idx_q;
  logic [TMR_W-1:0]         tmr_q;
  logic [3:0]               slot_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic                     e_sent_q;

  logic                     in_parse, rx_ev, is_digit, is_delim;
  logic                     digit_ev, minus_ev, tok_end;
  logic                     parse_err;
  logic [3:0]               parse_code;
  logic                     push_en;
  logic [7:0]               push_byte;

  assign state_out_o  = state_q;
  assign error_code_o = err_q;

  // Byte classification, token events and FSM next state.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    in_parse   = (state_q == S_PARSE_M) || (state_q == S_PARSE_N) || (state_q == S_PARSE_DATA);
    rx_ev      = rx_done_i && in_parse;
    is_digit   = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
    is_delim   = (rx_data_i == 8'h20) || (rx_data_i == 8'h2C) ||
                 (rx_data_i == 8'h0D) || (rx_data_i == 8'h0A);
    acc_nx     = (acc_q << 3) + (acc_q << 1) + ACC_W'(rx_data_i[3:0]);
    dcnt_nx    = dcnt_q + 1'b1;
    digit_ev   = 1'b0;
    minus_ev   = 1'b0;
    tok_end    = 1'b0;
    parse_err  = 1'b0;
    parse_code = E_NONE;

    if (rx_ev) begin
      if (is_digit) begin
        digit_ev = 1'b1;
        if (dcnt_nx > DC_W'(MAX_DIGITS)) begin
          parse_err  = 1'b1;
          parse_code = E_VALUE;
        end else if (state_q == S_PARSE_DATA &&
                     CMP_W'(acc_nx) > CMP_W'(cfg_max_value_i)) begin
          parse_err  = 1'b1;
          parse_code = E_VALUE;
        end
      end else if (is_delim) begin
        if (dcnt_q != '0) begin
          tok_end = 1'b1;
        end else if (sign_q) begin
          // a lone '-' followed by a delimiter
          parse_err  = 1'b1;
          parse_code = E_SYNTAX;
        end
      end
`ifdef MATRIX_INPUT_SIGNED_EN
      else if (rx_data_i == 8'h2D && state_q == S_PARSE_DATA && dcnt_q == '0 && !sign_q) begin
        minus_ev = 1'b1;
      end
`endif
      else begin
        parse_err  = 1'b1;
        parse_code = E_SYNTAX;
      end
    end

    case (state_q)
      S_IDLE: begin
        err_d   = E_NONE;
        state_d = S_PARSE_M;
      end
      S_PARSE_M:  if (tok_end) state_d = S_PARSE_N;
      S_PARSE_N:  if (tok_end) state_d = S_CHECK_DIM;
      S_CHECK_DIM: begin
        if (m_q == '0 || n_q == '0 ||
            m_q > ACC_W'(cfg_max_dim_i) || n_q > ACC_W'(cfg_max_dim_i)) begin
          state_d = S_ERROR;
          err_d   = E_DIM;
        end else begin
          state_d = S_WAIT_ALLOC;
        end
      end
      S_WAIT_ALLOC: begin
        if (alloc_ack_i) begin
          state_d = S_PARSE_DATA;
        end else if (alloc_fail_i || tmr_q == '0) begin
          state_d = S_ERROR;
          err_d   = E_SPACE;
        end
      end
      S_PARSE_DATA: if (tok_end && (idx_q + 8'd1 == total_q)) state_d = S_COMMIT;
      S_COMMIT:   state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_IDLE;
    endcase

    if (parse_err) begin
      state_d = S_ERROR;
      err_d   = parse_code;
    end
    if (!mode_active_i) begin
      state_d = S_IDLE;
      err_d   = E_NONE;
    end
  end

  // FSM state, token datapath and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      err_q         <= E_NONE;
      acc_q         <= '0;
      dcnt_q        <= '0;
      sign_q        <= 1'b0;
      m_q           <= '0;
      n_q           <= '0;
      total_q       <= '0;
      idx_q         <= '0;
      tmr_q         <= '0;
      slot_q        <= '0;
      base_q        <= '0;
      e_sent_q      <= 1'b0;
      alloc_req_o   <= 1'b0;
      alloc_m_o     <= '0;
      alloc_n_o     <= '0;
      commit_req_o  <= 1'b0;
      commit_slot_o <= '0;
      commit_m_o    <= '0;
      commit_n_o    <= '0;
      commit_addr_o <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      mem_wr_en_o  <= 1'b0;
      commit_req_o <= 1'b0;
      if (!mode_active_i || state_q == S_IDLE) begin
        acc_q       <= '0;
        dcnt_q      <= '0;
        sign_q      <= 1'b0;
        idx_q       <= '0;
        e_sent_q    <= 1'b0;
        alloc_req_o <= 1'b0;
        if (!mode_active_i) begin
          alloc_m_o     <= '0;
          alloc_n_o     <= '0;
          commit_slot_o <= '0;
          commit_m_o    <= '0;
          commit_n_o    <= '0;
          commit_addr_o <= '0;
          mem_wr_addr_o <= '0;
          mem_wr_data_o <= '0;
        end
      end else begin
        if (digit_ev) begin
          acc_q  <= acc_nx;
          dcnt_q <= dcnt_nx;
        end
        if (minus_ev) sign_q <= 1'b1;
        if (tok_end) begin
          acc_q  <= '0;
          dcnt_q <= '0;
          sign_q <= 1'b0;
        end
        case (state_q)
          S_PARSE_M: if (tok_end) m_q <= acc_q;
          S_PARSE_N: if (tok_end) n_q <= acc_q;
          S_CHECK_DIM: begin
            if (state_d == S_WAIT_ALLOC) begin
              total_q     <= m_q[3:0] * n_q[3:0];
              alloc_req_o <= 1'b1;
              alloc_m_o   <= m_q[3:0];
              alloc_n_o   <= n_q[3:0];
              tmr_q       <= TMR_W'(ALLOC_TIMEOUT);
            end
          end
          S_WAIT_ALLOC: begin
            if (alloc_ack_i) begin
              slot_q      <= alloc_slot_i;
              base_q      <= alloc_addr_i;
              alloc_req_o <= 1'b0;
            end else if (alloc_fail_i || tmr_q == '0) begin
              alloc_req_o <= 1'b0;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          S_PARSE_DATA: begin
            if (tok_end) begin
              mem_wr_en_o   <= 1'b1;
              mem_wr_addr_o <= base_q + ADDR_WIDTH'(idx_q);
              mem_wr_data_o <= sign_q ? ELEMENT_WIDTH'(ACC_W'(0) - acc_q)
                                      : ELEMENT_WIDTH'(acc_q);
              idx_q         <= idx_q + 8'd1;
            end
          end
          S_COMMIT: begin
            commit_req_o  <= 1'b1;
            commit_slot_o <= slot_q;
            commit_m_o    <= m_q[3:0];
            commit_n_o    <= n_q[3:0];
            commit_addr_o <= base_q;
          end
          S_ERROR: e_sent_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Echo FIFO push source: parsed bytes, or one status byte from DONE/ERROR.
  always_comb begin
    push_en   = 1'b0;
    push_byte = rx_data_i;
    if (mode_active_i) begin
      if (rx_ev) begin
        push_en = 1'b1;
      end else if (state_q == S_DONE) begin
        push_en   = 1'b1;
        push_byte = 8'h43;
      end else if (state_q == S_ERROR && !e_sent_q) begin
        push_en   = 1'b1;
        push_byte = 8'h45;
      end
    end
  end

  logic [7:0]       fifo_mem [ECHO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop;

  // A full FIFO silently drops; a pop waits one idle cycle after each tx_start.
  assign push_ok = push_en && (cnt_q != CNT_W'(ECHO_DEPTH));
  assign pop     = (cnt_q != '0) && !tx_busy_i && !tx_start_o;

  // FIFO storage, no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_byte;
  end

  // FIFO pointers, occupancy and transmit strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      tx_start_o <= pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        tx_data_o <= fifo_mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser: full transfers, dimension/value/
// syntax/timeout errors, mode abort, echo FIFO overflow, optional sign.
module tb_matrix_input_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_active = 1'b1;
  logic [3:0] cfg_max_dim = 4'd15;
  logic [7:0] cfg_max_value = 8'd255;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       alloc_req;
  logic [3:0] alloc_m, alloc_n;
  logic       alloc_ack = 1'b0;
  logic       alloc_fail = 1'b0;
  logic [3:0] alloc_slot = 4'd0;
  logic [8:0] alloc_addr = 9'd0;
  logic       commit_req;
  logic [3:0] commit_slot, commit_m, commit_n;
  logic [8:0] commit_addr;
  logic       mem_wr_en;
  logic [8:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic [3:0] error_code, state_out;

  matrix_input_parser dut (
    .clk(clk), .rst_n(rst_n), .mode_active_i(mode_active),
    .cfg_max_dim_i(cfg_max_dim), .cfg_max_value_i(cfg_max_value),
    .rx_data_i(rx_data), .rx_done_i(rx_done),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_busy_i(tx_busy),
    .alloc_req_o(alloc_req), .alloc_m_o(alloc_m), .alloc_n_o(alloc_n),
    .alloc_ack_i(alloc_ack), .alloc_fail_i(alloc_fail),
    .alloc_slot_i(alloc_slot), .alloc_addr_i(alloc_addr),
    .commit_req_o(commit_req), .commit_slot_o(commit_slot),
    .commit_m_o(commit_m), .commit_n_o(commit_n), .commit_addr_o(commit_addr),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .error_code_o(error_code), .state_out_o(state_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [8:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] tx_q[$];
  int         commit_cnt = 0;
  logic [3:0] c_slot, c_m, c_n;
  logic [8:0] c_addr;

  // Record DUT transactions away from the active edge.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
    if (tx_start) tx_q.push_back(tx_data);
    if (commit_req) begin
      commit_cnt++;
      c_slot = commit_slot;
      c_m    = commit_m;
      c_n    = commit_n;
      c_addr = commit_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic restart();
    @(negedge clk);
    mode_active = 1'b0;
    repeat (2) @(negedge clk);
    mode_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_alloc();
    int n = 0;
    while (alloc_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack(input logic [3:0] slot, input logic [8:0] addr);
    @(negedge clk);
    alloc_ack  = 1'b1;
    alloc_slot = slot;
    alloc_addr = addr;
    @(negedge clk);
    alloc_ack = 1'b0;
  endtask

  int w0, t0, c0;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_state", state_out, 4'd0);
    check("rst_err", error_code, 4'd0);
    check("rst_alloc_req", alloc_req, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_to_parse_m", state_out, 4'd1);

    // Full 2x3 transfer
    w0 = wr_addr_q.size(); t0 = tx_q.size(); c0 = commit_cnt;
    send_str("2 3 ");
    wait_alloc();
    check("t1_alloc_req", alloc_req, 1'b1);
    check("t1_alloc_m", alloc_m, 4'd2);
    check("t1_alloc_n", alloc_n, 4'd3);
    check("t1_state_wait", state_out, 4'd4);
    ack(4'd2, 9'h040);
    check("t1_req_dropped", alloc_req, 1'b0);
    send_str("1 2 3 4 5 6 ");
    repeat (40) @(negedge clk);
    check("t1_nwrites", wr_addr_q.size() - w0, 6);
    for (int i = 0; i < 6; i++) begin
      if (w0 + i < wr_addr_q.size()) begin
        check("t1_wr_addr", wr_addr_q[w0+i], 9'h040 + 9'(i));
        check("t1_wr_data", wr_data_q[w0+i], 8'(i + 1));
      end
    end
    check("t1_commits", commit_cnt - c0, 1);
    check("t1_c_slot", c_slot, 4'd2);
    check("t1_c_m", c_m, 4'd2);
    check("t1_c_n", c_n, 4'd3);
    check("t1_c_addr", c_addr, 9'h040);
    check("t1_ntx", tx_q.size() - t0, 17);
    if (tx_q.size() >= t0 + 17) begin
      check("t1_echo_first", tx_q[t0], 8'h32);
      check("t1_status_c", tx_q[t0+16], 8'h43);
    end
    check("t1_back_parse_m", state_out, 4'd1);
    check("t1_err_none", error_code, 4'd0);

    // Multi-digit, mixed delimiters
    restart();
    w0 = wr_addr_q.size(); c0 = commit_cnt;
    send_str("1 2 ");
    wait_alloc();
    ack(4'd1, 9'h010);
    send_str("12,255\n");
    repeat (10) @(negedge clk);
    check("t2_nwrites", wr_addr_q.size() - w0, 2);
    if (wr_addr_q.size() >= w0 + 2) begin
      check("t2_wr0_addr", wr_addr_q[w0], 9'h010);
      check("t2_wr0_data", wr_data_q[w0], 8'd12);
      check("t2_wr1_addr", wr_addr_q[w0+1], 9'h011);
      check("t2_wr1_data", wr_data_q[w0+1], 8'd255);
    end
    check("t2_commits", commit_cnt - c0, 1);

    // Value over cfg_max_value
    restart();
    w0 = wr_addr_q.size(); t0 = tx_q.size(); c0 = commit_cnt;
    send_str("1 1 ");
    wait_alloc();
    ack(4'd0, 9'h000);
    send_str("256 ");
    repeat (30) @(negedge clk);
    check("t3_err_value", error_code, 4'd2);
    check("t3_state_err", state_out, 4'd8);
    check("t3_no_write", wr_addr_q.size() - w0, 0);
    check("t3_no_commit", commit_cnt - c0, 0);
    if (tx_q.size() > t0) check("t3_status_e", tx_q[tx_q.size()-1], 8'h45);
    else check("t3_tx_present", tx_q.size() - t0, 1);

    // Zero dimension
    restart();
    send_str("0 3 ");
    repeat (4) @(negedge clk);
    check("t4_err_dim0", error_code, 4'd1);
    check("t4_no_alloc", alloc_req, 1'b0);

    // Dimension above cfg_max_dim
    restart();
    send_str("16 1 ");
    repeat (4) @(negedge clk);
    check("t5_err_dim16", error_code, 4'd1);

    // Allocation never answered
    restart();
    send_str("2 2 ");
    wait_alloc();
    check("t6_alloc_req", alloc_req, 1'b1);
    repeat (200) @(negedge clk);
    check("t6_still_wait", state_out, 4'd4);
    check("t6_no_err_yet", error_code, 4'd0);
    repeat (100) @(negedge clk);
    check("t6_err_space", error_code, 4'd3);
    check("t6_req_dropped", alloc_req, 1'b0);

    // Syntax error in dimension
    restart();
    send_str("2 x");
    repeat (2) @(negedge clk);
    check("t7_err_syntax", error_code, 4'd4);

    // Too many digits
    restart();
    send_str("1000");
    repeat (2) @(negedge clk);
    check("t8_err_digits", error_code, 4'd2);

    // mode_active dropped mid PARSE_DATA
    restart();
    w0 = wr_addr_q.size(); c0 = commit_cnt;
    send_str("1 3 ");
    wait_alloc();
    ack(4'd3, 9'h020);
    send_str("7 8");
    check("t9_in_data", state_out, 4'd5);
    mode_active = 1'b0;
    @(negedge clk);
    check("t9_idle_next", state_out, 4'd0);
    repeat (5) @(negedge clk);
    check("t9_one_write", wr_addr_q.size() - w0, 1);
    check("t9_no_commit", commit_cnt - c0, 0);
    mode_active = 1'b1;
    repeat (40) @(negedge clk);

    // Echo FIFO overflow under tx_busy
    restart();
    tx_busy = 1'b1;
    t0 = tx_q.size();
    begin
      logic [7:0] seq [10];
      seq = '{8'h20, 8'h2C, 8'h0D, 8'h0A, 8'h20, 8'h2C, 8'h0D, 8'h0A, 8'h20, 8'h2C};
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        rx_data = seq[i];
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("t10_held_off", tx_q.size() - t0, 0);
      tx_busy = 1'b0;
      repeat (40) @(negedge clk);
      check("t10_n_echo", tx_q.size() - t0, 8);
      for (int i = 0; i < 8; i++)
        if (t0 + i < tx_q.size()) check("t10_echo_order", tx_q[t0+i], seq[i]);
      check("t10_no_err", error_code, 4'd0);
    end

    // Signed element handling (build dependent)
    restart();
    w0 = wr_addr_q.size();
    send_str("1 2 ");
    wait_alloc();
    ack(4'd4, 9'h030);
    send_str("-5 7 ");
    repeat (10) @(negedge clk);
`ifdef MATRIX_INPUT_SIGNED_EN
    check("t11_nwrites", wr_addr_q.size() - w0, 2);
    if (wr_addr_q.size() >= w0 + 2) begin
      check("t11_neg", wr_data_q[w0], 8'hFB);
      check("t11_pos", wr_data_q[w0+1], 8'h07);
    end
    check("t11_err_none", error_code, 4'd0);
`else
    check("t11_minus_syntax", error_code, 4'd4);
    check("t11_no_write", wr_addr_q.size() - w0, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
